lit_assign_trail: RTL and testbench

Assignment tracker and decision trail for the DPLL datapath. It receives a literal index chosen by the random-literal picker (index plus valid) and records it as assigned. It keeps the literal's polarity and pushes the index onto a LIFO trail so the solver can backtrack. Its `lit_assigned` output is the status vector fed back into the picker, which closes the pick/assign loop.

---
 rtl/lit_assign_trail.sv | 105 ++++++++++
 tb/tb_lit_assign_trail.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lit_assign_trail.sv
// Assignment tracker and LIFO decision trail for the DPLL datapath.
// Records picked literals with their polarity and unwinds them on backtrack or clear.
module lit_assign_trail #(
    parameter int WIDTH = 4,
    parameter int N     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] lit_in,
    input  logic             lit_valid,
    input  logic             lit_pol,
    input  logic             backtrack,
    input  logic             clear,
    output logic [N-1:0]     lit_assigned,
    output logic [N-1:0]     lit_value,
    output logic [WIDTH:0]   level,
    output logic [WIDTH-1:0] top_lit,
    output logic             empty,
    output logic             full,
    output logic             all_assigned,
    output logic             busy,
    output logic             err
);

    typedef enum logic {
        IDLE,
        UNWIND
    } state_t;

    localparam logic [WIDTH:0] LVL_FULL = (WIDTH+1)'(N);

    state_t           state;
    logic [WIDTH-1:0] trail [N];
    logic [WIDTH-1:0] top_ptr;
    logic [WIDTH-1:0] top_idx;
    logic             push_en;

    always_comb begin
        empty        = (level == '0);
        full         = (level == LVL_FULL);
        all_assigned = &lit_assigned;
        busy         = (state == UNWIND);
        // low WIDTH bits minus one also yields N-1 when level == N
        top_ptr      = level[WIDTH-1:0] - 1'b1;
        top_idx      = trail[top_ptr];
        top_lit      = empty ? '0 : top_idx;
        push_en      = (state == IDLE) && !clear && !backtrack && lit_valid
                       && !lit_assigned[lit_in] && !full;
    end

    // Trail RAM: contents are don't-care after reset, so no reset branch.
    always_ff @(posedge clk) begin
        if (push_en)
            trail[level[WIDTH-1:0]] <= lit_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            lit_assigned <= '0;
            lit_value    <= '0;
            level        <= '0;
            err          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        state <= UNWIND;
                    end else if (backtrack) begin
                        if (!empty) begin
                            lit_assigned[top_idx] <= 1'b0;
                            lit_value[top_idx]    <= 1'b0;
                            level                 <= level - 1'b1;
                            if (lit_valid)
                                err <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (lit_valid) begin
                        if (push_en) begin
                            lit_assigned[lit_in] <= 1'b1;
                            lit_value[lit_in]    <= lit_pol;
                            level                <= level + 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                UNWIND: begin
                    if (!empty) begin
                        lit_assigned[top_idx] <= 1'b0;
                        lit_value[top_idx]    <= 1'b0;
                        level                 <= level - 1'b1;
                        if (level == {{WIDTH{1'b0}}, 1'b1})
                            state <= IDLE;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lit_assign_trail.sv
// Self-checking bench for lit_assign_trail: queue-based reference model, per-cycle
// compare on the falling edge, directed cases plus randomized traffic.
module tb_lit_assign_trail;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  lit_in;
    logic        lit_valid, lit_pol, backtrack, clear;
    logic [15:0] lit_assigned, lit_value;
    logic [4:0]  level;
    logic [3:0]  top_lit;
    logic        empty, full, all_assigned, busy, err;

    always #5 clk = ~clk;

    lit_assign_trail #(.WIDTH(4), .N(16)) dut (
        .clk(clk), .rst(rst), .lit_in(lit_in), .lit_valid(lit_valid),
        .lit_pol(lit_pol), .backtrack(backtrack), .clear(clear),
        .lit_assigned(lit_assigned), .lit_value(lit_value), .level(level),
        .top_lit(top_lit), .empty(empty), .full(full),
        .all_assigned(all_assigned), .busy(busy), .err(err)
    );

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Reference model: trail as a queue, status as plain bit vectors.
    int        m_q[$];
    bit [15:0] m_asg, m_val;
    bit        m_err, m_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_asg  = '0;
        m_val  = '0;
        m_err  = 1'b0;
        m_busy = 1'b0;
    endtask

    task automatic model_pop();
        int t;
        t = m_q.pop_back();
        m_asg[t] = 1'b0;
        m_val[t] = 1'b0;
    endtask

    task automatic model_edge(input bit v, input int l, input bit p, input bit b, input bit c);
        if (m_busy) begin
            if (m_q.size() > 0) model_pop();
            if (m_q.size() == 0) m_busy = 1'b0;
        end else if (c) begin
            m_busy = 1'b1;
        end else if (b) begin
            if (m_q.size() > 0) begin
                model_pop();
                if (v) m_err = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end else if (v) begin
            if (!m_asg[l] && m_q.size() < 16) begin
                m_q.push_back(l);
                m_asg[l] = 1'b1;
                m_val[l] = p;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic step(input bit v, input int l, input bit p, input bit b, input bit c);
        lit_valid = v;
        lit_in    = l[3:0];
        lit_pol   = p;
        backtrack = b;
        clear     = c;
        @(posedge clk);
        if (rst) model_edge(v, l, p, b, c);
        #1;
    endtask

    task automatic do_reset();
        lit_valid = 1'b0; lit_in = '0; lit_pol = 1'b0; backtrack = 1'b0; clear = 1'b0;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("lit_assigned", lit_assigned, m_asg);
            check("lit_value", lit_value, m_val);
            check("level", level, m_q.size());
            check("top_lit", top_lit, (m_q.size() > 0) ? m_q[$] : 0);
            check("empty", empty, m_q.size() == 0);
            check("full", full, m_q.size() == 16);
            check("all_assigned", all_assigned, &m_asg);
            check("busy", busy, m_busy);
            check("err", err, m_err);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int guard;
        lit_valid = 1'b0; lit_in = '0; lit_pol = 1'b0; backtrack = 1'b0; clear = 1'b0;
        rst = 1'b0;
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_assigned", lit_assigned, 16'h0000);
        check("rst_empty", empty, 1'b1);
        check("rst_level", level, 5'd0);
        check("rst_err", err, 1'b0);
        rst = 1'b1;

        // push sequence
        step(1, 3, 1, 0, 0);
        step(1, 7, 0, 0, 0);
        step(1, 15, 1, 0, 0);
        check("push_assigned", lit_assigned, 16'h8088);
        check("push_value", lit_value, 16'h8008);
        check("push_level", level, 5'd3);
        check("push_top", top_lit, 4'd15);
        check("push_err", err, 1'b0);

        // duplicate push
        step(1, 7, 1, 0, 0);
        check("dup_level", level, 5'd3);
        check("dup_assigned", lit_assigned, 16'h8088);
        check("dup_err", err, 1'b1);
        step(0, 0, 0, 0, 0);
        check("dup_err_hold", err, 1'b1);

        // backtracks
        step(0, 0, 0, 1, 0);
        check("bt1_level", level, 5'd2);
        check("bt1_top", top_lit, 4'd7);
        check("bt1_assigned", lit_assigned, 16'h0088);
        step(0, 0, 0, 1, 0);
        check("bt2_top", top_lit, 4'd3);
        check("bt2_assigned", lit_assigned, 16'h0008);
        step(0, 0, 0, 1, 0);
        check("bt3_level", level, 5'd0);
        check("bt3_top", top_lit, 4'd0);
        check("bt3_empty", empty, 1'b1);
        do_reset();
        check("bt_rst_err", err, 1'b0);
        step(0, 0, 0, 1, 0);
        check("bt_empty_err", err, 1'b1);
        check("bt_empty_level", level, 5'd0);

        // fill to full
        do_reset();
        for (int i = 0; i < 16; i++) step(1, i, i % 2, 0, 0);
        check("fill_full", full, 1'b1);
        check("fill_all", all_assigned, 1'b1);
        check("fill_level", level, 5'd16);
        check("fill_value", lit_value, 16'hAAAA);
        check("fill_err", err, 1'b0);
        step(1, 5, 0, 0, 0);
        check("over_err", err, 1'b1);
        check("over_level", level, 5'd16);
        check("over_value", lit_value, 16'hAAAA);

        // clear from full with noise during unwind
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 15 - i, i % 2, 0, 0);
        step(0, 0, 0, 0, 1);
        cnt = 0;
        guard = 0;
        while (busy && guard < 40) begin
            cnt++;
            guard++;
            step($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1));
        end
        check("clr_busy_cycles", cnt, 16);
        check("clr_assigned", lit_assigned, 16'h0000);
        check("clr_err", err, 1'b0);
        check("clr_busy", busy, 1'b0);

        // simultaneous push and backtrack
        do_reset();
        step(1, 1, 1, 0, 0);
        step(1, 4, 0, 0, 0);
        step(1, 9, 1, 1, 0);
        check("sim_level", level, 5'd1);
        check("sim_lit9", lit_assigned[9], 1'b0);
        check("sim_err", err, 1'b1);

        // reset mid-unwind
        step(1, 2, 1, 0, 0);
        step(1, 6, 0, 0, 0);
        step(1, 10, 1, 0, 0);
        step(1, 12, 1, 0, 0);
        check("pre_clr_level", level, 5'd5);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("mid_unwind_level", level, 5'd3);
        rst = 1'b0;
        model_reset();
        #1;
        check("mrst_assigned", lit_assigned, 16'h0000);
        check("mrst_value", lit_value, 16'h0000);
        check("mrst_level", level, 5'd0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_err", err, 1'b0);
        check("mrst_empty", empty, 1'b1);
        @(posedge clk);
        #1;
        check("mrst_hold_level", level, 5'd0);
        rst = 1'b1;

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if (n % 250 == 249) do_reset();
            step(($urandom % 4) != 0, $urandom_range(0, 15), $urandom_range(0, 1),
                 ($urandom % 5) == 0, ($urandom % 64) == 0);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
